// File: rtl/uart_mult_byte_tx.sv
// ---------------------------------------------------------------------------
// uart_mult_byte_tx
//
// Multi-byte UART packet transmitter (8N1, LSB first). A single tx_start
// pulse latches up to 11 payload bytes and sends one contiguous frame:
//   HEADER, len, tx_data0 .. tx_data[len-1] [, CRC8]
// The length is clamped to 11 and a zero length request is dropped.
//
// Optional feature macro: UART_TX_CRC8_EN
//   defined   -> a CRC8 byte (poly 0x07, init 0x00, no reflection, no final
//                XOR) over the length and payload bytes closes the frame.
//   undefined -> no CRC logic; the frame ends after the last payload byte.
//
// Parameters:
//   CLK_FREQ  input clock frequency in Hz
//   UART_BPS  baud rate; one bit lasts CLK_FREQ/UART_BPS clock cycles
//   HEADER    first byte of every frame
//
// Ports:
//   sys_clk              clock, all logic on rising edge
//   sys_rst              asynchronous active-high reset
//   tx_start             one-cycle request, only honoured while idle
//   pack_len[7:0]        payload byte count, valid with tx_start
//   tx_data0..tx_data10  payload bytes, tx_data0 goes out first
//   uart_txd             serial output, idle high
//   tx_busy              high while a frame is on the line
//   tx_done              one-cycle pulse after the last stop bit
//   byte_cnt[3:0]        index of the frame byte on the line (0 = header)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_mult_byte_tx #(
    parameter int          CLK_FREQ = 50_000_000,
    parameter int          UART_BPS = 115200,
    parameter logic [7:0]  HEADER   = 8'h5A
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       tx_start,
    input  logic [7:0] pack_len,
    input  logic [7:0] tx_data0,
    input  logic [7:0] tx_data1,
    input  logic [7:0] tx_data2,
    input  logic [7:0] tx_data3,
    input  logic [7:0] tx_data4,
    input  logic [7:0] tx_data5,
    input  logic [7:0] tx_data6,
    input  logic [7:0] tx_data7,
    input  logic [7:0] tx_data8,
    input  logic [7:0] tx_data9,
    input  logic [7:0] tx_data10,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [3:0] byte_cnt
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BPS_CNT - 1);
    localparam int MAX_LEN = 11;

    // Frame index of the last byte = len + number of bytes after the payload
    // tail (length byte offset plus the optional CRC byte).
`ifdef UART_TX_CRC8_EN
    localparam logic [3:0] TRAILER = 4'd2;
`else
    localparam logic [3:0] TRAILER = 4'd1;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_DONE
    } state_t;

    state_t            state_reg,    state_next;
    logic [CNT_W-1:0]  baud_cnt_reg, baud_cnt_next;
    logic [2:0]        bit_cnt_reg,  bit_cnt_next;
    logic [3:0]        byte_cnt_reg, byte_cnt_next;
    logic [3:0]        last_idx_reg, last_idx_next;
    logic [3:0]        len_reg,      len_next;
    logic [7:0]        shift_reg,    shift_next;
    logic              txd_reg,      txd_next;
    logic              busy_reg,     busy_next;
    logic              done_reg,     done_next;
`ifdef UART_TX_CRC8_EN
    logic [7:0]        crc_reg,      crc_next;
`endif

    logic [7:0] payload_in [0:MAX_LEN-1];
    logic [7:0] buf_rd     [0:MAX_LEN-1];
    logic       accept;
    logic [3:0] len_clamped;
    logic [3:0] next_idx;
    logic [3:0] pay_idx;
    logic [7:0] next_byte;

    assign payload_in[0]  = tx_data0;
    assign payload_in[1]  = tx_data1;
    assign payload_in[2]  = tx_data2;
    assign payload_in[3]  = tx_data3;
    assign payload_in[4]  = tx_data4;
    assign payload_in[5]  = tx_data5;
    assign payload_in[6]  = tx_data6;
    assign payload_in[7]  = tx_data7;
    assign payload_in[8]  = tx_data8;
    assign payload_in[9]  = tx_data9;
    assign payload_in[10] = tx_data10;

    assign accept      = (state_reg == ST_IDLE) && tx_start && (pack_len != 8'd0);
    assign len_clamped = (pack_len > 8'd11) ? 4'd11 : pack_len[3:0];

    // Payload buffer: every slot is captured in the accept cycle so later
    // input changes cannot disturb the frame in flight. Data-only storage,
    // so no reset is needed here.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_slot
            logic [7:0] slot_reg;
            always_ff @(posedge sys_clk) begin
                if (accept) begin
                    slot_reg <= payload_in[gi];
                end
            end
            assign buf_rd[gi] = slot_reg;
        end
    endgenerate

`ifdef UART_TX_CRC8_EN
    // One byte step of CRC8, poly 0x07, MSB first.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                             input logic [7:0] data_in);
        logic [7:0] c;
        c = crc_in ^ data_in;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`endif

    // Byte that follows the one currently on the line. Frame index 1 is the
    // length byte, indices 2.. map onto buffer slots 0..
    assign next_idx = byte_cnt_reg + 4'd1;
    assign pay_idx  = next_idx - 4'd2;

    always_comb begin
        next_byte = buf_rd[pay_idx];
        if (next_idx == 4'd1) begin
            next_byte = {4'd0, len_reg};
        end
`ifdef UART_TX_CRC8_EN
        else if (next_idx == last_idx_reg) begin
            next_byte = crc_reg;
        end
`endif
    end

    // Next-state logic.
    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        byte_cnt_next = byte_cnt_reg;
        last_idx_next = last_idx_reg;
        len_next      = len_reg;
        shift_next    = shift_reg;
`ifdef UART_TX_CRC8_EN
        crc_next      = crc_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next    = ST_START;
                    baud_cnt_next = '0;
                    bit_cnt_next  = 3'd0;
                    byte_cnt_next = 4'd0;
                    len_next      = len_clamped;
                    last_idx_next = len_clamped + TRAILER;
                    shift_next    = HEADER;
`ifdef UART_TX_CRC8_EN
                    crc_next      = 8'h00;
`endif
                end
            end

            ST_START: begin
                if (baud_cnt_reg == BAUD_LAST) begin
                    baud_cnt_next = '0;
                    state_next    = ST_DATA;
                end else begin
                    baud_cnt_next = baud_cnt_reg + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (baud_cnt_reg == BAUD_LAST) begin
                    baud_cnt_next = '0;
                    // Shift right so the next data bit is always at bit 0.
                    shift_next    = shift_reg >> 1;
                    if (bit_cnt_reg == 3'd7) begin
                        bit_cnt_next = 3'd0;
                        state_next   = ST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + CNT_W'(1);
                end
            end

            ST_STOP: begin
                if (baud_cnt_reg == BAUD_LAST) begin
                    baud_cnt_next = '0;
                    if (byte_cnt_reg == last_idx_reg) begin
                        state_next = ST_DONE;
                    end else begin
                        // Next start bit follows immediately: no idle gap.
                        state_next    = ST_START;
                        byte_cnt_next = next_idx;
                        shift_next    = next_byte;
`ifdef UART_TX_CRC8_EN
                        // CRC accumulates as bytes are loaded; the CRC byte
                        // itself is not folded in.
                        if (next_idx != last_idx_reg) begin
                            crc_next = crc8_byte(crc_reg, next_byte);
                        end
`endif
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_next    = ST_IDLE;
                byte_cnt_next = 4'd0;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered and derived from the upcoming state so that
    // the line and the status flags change together with the state.
    always_comb begin
        txd_next  = 1'b1;
        busy_next = 1'b0;
        done_next = 1'b0;
        case (state_next)
            ST_START: begin
                txd_next  = 1'b0;
                busy_next = 1'b1;
            end
            ST_DATA: begin
                txd_next  = shift_next[0];
                busy_next = 1'b1;
            end
            ST_STOP: begin
                busy_next = 1'b1;
            end
            ST_DONE: begin
                done_next = 1'b1;
            end
            default: begin
                txd_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= 3'd0;
            byte_cnt_reg <= 4'd0;
            last_idx_reg <= 4'd0;
            len_reg      <= 4'd0;
            shift_reg    <= 8'd0;
            txd_reg      <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
`ifdef UART_TX_CRC8_EN
            crc_reg      <= 8'h00;
`endif
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            byte_cnt_reg <= byte_cnt_next;
            last_idx_reg <= last_idx_next;
            len_reg      <= len_next;
            shift_reg    <= shift_next;
            txd_reg      <= txd_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
`ifdef UART_TX_CRC8_EN
            crc_reg      <= crc_next;
`endif
        end
    end

    assign uart_txd = txd_reg;
    assign tx_busy  = busy_reg;
    assign tx_done  = done_reg;
    assign byte_cnt = byte_cnt_reg;

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_mult_byte_tx
//
// Self-checking bench for uart_mult_byte_tx with BPS_CNT = 10. A frame-level
// model (list of frame bytes plus elapsed cycles) predicts the line, busy,
// done and byte index every cycle; an independent serial decoder recovers
// the bytes for per-frame comparisons against literal and model frames.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_mult_byte_tx;

    localparam int CLK_FREQ = 1_000_000;
    localparam int UART_BPS = 100_000;
    localparam int BPS      = CLK_FREQ / UART_BPS;
`ifdef UART_TX_CRC8_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif
    localparam int EXP_T1 = CRC_ON ? 400 : 300;

    typedef logic [7:0] byte_q_t [$];

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] pack_len = 8'd0;
    logic [7:0] tx_data [0:10];
    logic       uart_txd;
    logic       tx_busy;
    logic       tx_done;
    logic [3:0] byte_cnt;

    uart_mult_byte_tx #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS),
        .HEADER   (8'h5A)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .tx_start  (tx_start),
        .pack_len  (pack_len),
        .tx_data0  (tx_data[0]),
        .tx_data1  (tx_data[1]),
        .tx_data2  (tx_data[2]),
        .tx_data3  (tx_data[3]),
        .tx_data4  (tx_data[4]),
        .tx_data5  (tx_data[5]),
        .tx_data6  (tx_data[6]),
        .tx_data7  (tx_data[7]),
        .tx_data8  (tx_data[8]),
        .tx_data9  (tx_data[9]),
        .tx_data10 (tx_data[10]),
        .uart_txd  (uart_txd),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .byte_cnt  (byte_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int checks    = 0;
    int errors    = 0;
    int cycle     = 0;
    int start_cyc = 0;
    int done_cyc  = 0;
    int done_cnt  = 0;
    int frame_no  = 0;
    byte_q_t rx_q;

    // Model state: the frame being sent and cycles elapsed since its start.
    bit      m_active = 1'b0;
    bit      m_done   = 1'b0;
    int      m_t      = 0;
    byte_q_t m_frame;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bit-serial polynomial division, MSB first.
    function automatic logic [7:0] crc8_ref(input byte_q_t msg);
        logic [7:0] r;
        bit         fb;
        r = 8'h00;
        foreach (msg[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = r[7] ^ msg[i][b];
                r  = {r[6:0], 1'b0};
                if (fb) r = r ^ 8'h07;
            end
        end
        return r;
    endfunction

    function automatic byte_q_t build_frame(input int len);
        byte_q_t f;
        byte_q_t body;
        int      l;
        l = (len > 11) ? 11 : len;
        f.push_back(8'h5A);
        f.push_back(8'(l));
        for (int i = 0; i < l; i++) f.push_back(tx_data[i]);
        if (CRC_ON) begin
            body = f[1:$];
            f.push_back(crc8_ref(body));
        end
        return f;
    endfunction

    // Per-cycle compare against the model, plus event bookkeeping.
    initial begin : compare_proc
        logic exp_txd, exp_busy, exp_done;
        int   exp_bc, b, pos;
        bit   prev_busy;
        prev_busy = 1'b0;
        forever begin
            @(negedge sys_clk);
            cycle++;
            if (tx_busy === 1'b1 && !prev_busy) start_cyc = cycle;
            if (tx_done === 1'b1) begin
                done_cyc = cycle;
                done_cnt++;
            end
            prev_busy = (tx_busy === 1'b1);
            if (sys_rst) begin
                checks++;
                if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || byte_cnt !== 4'd0) begin
                    errors++;
                    $display("FAIL reset_state @%0d: got txd=%b busy=%b done=%b byte_cnt=%0d, expected 1 0 0 0",
                             cycle, uart_txd, tx_busy, tx_done, byte_cnt);
                end
                m_active = 1'b0;
                m_done   = 1'b0;
            end else begin
                exp_txd  = 1'b1;
                exp_busy = 1'b0;
                exp_done = 1'b0;
                exp_bc   = -1;
                if (m_active) begin
                    b        = m_t / BPS;
                    exp_bc   = b / 10;
                    pos      = b % 10;
                    exp_busy = 1'b1;
                    if (pos == 0)      exp_txd = 1'b0;
                    else if (pos == 9) exp_txd = 1'b1;
                    else               exp_txd = m_frame[exp_bc][pos-1];
                end else if (m_done) begin
                    exp_done = 1'b1;
                end
                checks++;
                if (uart_txd !== exp_txd || tx_busy !== exp_busy || tx_done !== exp_done ||
                    (exp_bc >= 0 && byte_cnt !== 4'(exp_bc))) begin
                    errors++;
                    $display("FAIL cycle_compare @%0d: got txd=%b busy=%b done=%b byte_cnt=%0d, expected txd=%b busy=%b done=%b byte_cnt=%0d",
                             cycle, uart_txd, tx_busy, tx_done, byte_cnt, exp_txd, exp_busy, exp_done, exp_bc);
                end
                // Advance to the next cycle using the inputs sampled at the next edge.
                if (m_active) begin
                    m_t++;
                    if (m_t == m_frame.size() * 10 * BPS) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end else if (m_done) begin
                    m_done = 1'b0;
                end else if (tx_start === 1'b1 && pack_len != 8'd0) begin
                    m_frame  = build_frame(int'(pack_len));
                    m_t      = 0;
                    m_active = 1'b1;
                end
            end
        end
    end

    // Independent serial decoder: mid-bit sampling after each falling edge.
    initial begin : rx_proc
        int         c;
        bit         rx_busy;
        logic [7:0] sh;
        rx_busy = 1'b0;
        c       = 0;
        sh      = 8'd0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                rx_busy = 1'b0;
            end else if (!rx_busy) begin
                if (uart_txd === 1'b0) begin
                    rx_busy = 1'b1;
                    c       = 0;
                end
            end else begin
                c++;
                if (c % BPS == BPS / 2) begin
                    if (c / BPS >= 1 && c / BPS <= 8) begin
                        sh = {uart_txd, sh[7:1]};
                    end else if (c / BPS == 9) begin
                        rx_q.push_back(sh);
                        rx_busy = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #10_000_000;
        $display("FAIL watchdog: got no end of test, expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic send(input int len);
        @(posedge sys_clk); #1;
        tx_start = 1'b1;
        pack_len = 8'(len);
        @(posedge sys_clk); #1;
        tx_start = 1'b0;
        pack_len = 8'($urandom);
        foreach (tx_data[i]) tx_data[i] = 8'($urandom);
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge sys_clk);
            if (tx_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
        check({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_rx(input string name, input byte_q_t exp);
        frame_no++;
        $display("frame %0d %s: sent %0d bytes, decoded %0d bytes, done at cycle %0d",
                 frame_no, name, exp.size(), rx_q.size(), done_cyc);
        check({name, "_nbytes"}, 32'(rx_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
            check($sformatf("%s_byte%0d", name, i), 32'(rx_q[i]), 32'(exp[i]));
        end
    endtask

    initial begin : stimulus
        byte_q_t lit;
        byte_q_t expf;
        byte_q_t probe;
        int      dc, len, span;
        bit      seen;

        foreach (tx_data[i]) tx_data[i] = 8'd0;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;

        // Model pin: CRC8 of {0x01, 0x01} worked by hand is 0x12.
        probe = '{8'h01, 8'h01};
        check("model_crc8", 32'(crc8_ref(probe)), 32'h12);

        // Single payload byte 0x01.
        lit = '{8'h5A, 8'h01, 8'h01};
        if (CRC_ON) lit.push_back(8'h12);
        tx_data[0] = 8'h01;
        expf = build_frame(1);
        check("model_t1_size", 32'(expf.size()), 32'(lit.size()));
        rx_q.delete();
        dc = done_cnt;
        send(1);
        wait_done("t1", 600);
        check_rx("t1", lit);
        check("t1_duration", 32'(done_cyc - start_cyc), 32'(EXP_T1));
        check("t1_done_count", 32'(done_cnt - dc), 32'd1);

        // Full length payload 0x00..0x0A.
        foreach (tx_data[i]) tx_data[i] = 8'(i);
        expf = build_frame(11);
        rx_q.delete();
        send(11);
        wait_done("t11", 1600);
        check_rx("t11", expf);
        check("t11_nbytes_lit", 32'(rx_q.size()), CRC_ON ? 32'd14 : 32'd13);
        check("t11_len_byte", 32'(rx_q[1]), 32'h0B);
        check("t11_last_payload", 32'(rx_q[12]), 32'h0A);
        check("t11_duration", 32'(done_cyc - start_cyc), 32'(expf.size() * 10 * BPS));

        // Zero length is dropped.
        rx_q.delete();
        dc = done_cnt;
        send(0);
        repeat (40) @(posedge sys_clk);
        #1;
        check("zero_len_done", 32'(done_cnt - dc), 32'd0);
        check("zero_len_rx", 32'(rx_q.size()), 32'd0);
        check("zero_len_busy", 32'(tx_busy), 32'd0);

        // Oversized length clamps to 11.
        foreach (tx_data[i]) tx_data[i] = 8'($urandom);
        expf = build_frame(15);
        rx_q.delete();
        send(15);
        wait_done("t15", 1600);
        check_rx("t15", expf);
        check("t15_len_byte", 32'(rx_q[1]), 32'h0B);

        // Second request mid-frame is ignored.
        foreach (tx_data[i]) tx_data[i] = 8'($urandom);
        expf = build_frame(6);
        rx_q.delete();
        dc = done_cnt;
        send(6);
        repeat (200) @(posedge sys_clk);
        foreach (tx_data[i]) tx_data[i] = 8'($urandom);
        send(3);
        wait_done("busy_ign", 1000);
        check_rx("busy_ign", expf);
        check("busy_ign_done1", 32'(done_cnt - dc), 32'd1);
        repeat (50) @(posedge sys_clk);
        #1;
        check("busy_ign_idle", 32'(tx_busy), 32'd0);
        check("busy_ign_done_after", 32'(done_cnt - dc), 32'd1);

        // Reset during byte 3 (tx_data1 = 0 keeps the line low there).
        foreach (tx_data[i]) tx_data[i] = 8'($urandom);
        tx_data[1] = 8'h00;
        send(5);
        seen = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge sys_clk);
            if (byte_cnt === 4'd3) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_reach_byte3", 32'(seen), 32'd1);
        repeat (37) @(posedge sys_clk);
        #1;
        dc = done_cnt;
        sys_rst = 1'b1;
        #1;
        check("rst_async_txd", 32'(uart_txd), 32'd1);
        check("rst_async_busy", 32'(tx_busy), 32'd0);
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        repeat (30) @(posedge sys_clk);
        #1;
        check("rst_no_done", 32'(done_cnt - dc), 32'd0);
        check("rst_idle_busy", 32'(tx_busy), 32'd0);
        foreach (tx_data[i]) tx_data[i] = 8'($urandom);
        expf = build_frame(4);
        rx_q.delete();
        send(4);
        wait_done("post_rst", 1000);
        check_rx("post_rst", expf);

        // Randomised frames, back to back, with occasional ignored requests.
        for (int it = 0; it < 20; it++) begin
            len = $urandom_range(0, 15);
            foreach (tx_data[i]) tx_data[i] = 8'($urandom);
            expf = build_frame(len);
            rx_q.delete();
            dc = done_cnt;
            send(len);
            if (len == 0) begin
                repeat (30) @(posedge sys_clk);
                #1;
                check("rand_zero_done", 32'(done_cnt - dc), 32'd0);
                check("rand_zero_rx", 32'(rx_q.size()), 32'd0);
            end else begin
                if ($urandom_range(0, 2) == 0) begin
                    span = expf.size() * 10 * BPS;
                    repeat ($urandom_range(1, span - 20)) @(posedge sys_clk);
                    send($urandom_range(1, 15));
                end
                wait_done("rand", expf.size() * 10 * BPS + 20);
                check_rx("rand", expf);
                check("rand_done1", 32'(done_cnt - dc), 32'd1);
            end
        end

        repeat (20) @(posedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_mult_byte_tx.md
# uart_mult_byte_tx

Multi-byte UART packet transmitter: the transmit-side counterpart of the multi-byte receiver. On a start pulse it latches up to 11 payload bytes and serialises one framed packet on `uart_txd`, 8N1, LSB first: header, length, payload and optional CRC8. It sits in the `clk_50M` domain beside the register mapper and produces the response/status frames returned to the host.

## Interface
- `CLK_FREQ`, 50_000_000, input clock frequency in Hz.
- `UART_BPS`, 115200, baud rate; `BPS_CNT = CLK_FREQ/UART_BPS` (integer divide; 434 at defaults).
- `HEADER`, 8'h5A, first byte of every frame.

Ports:
- `sys_clk`  in  1  single clock; all logic on rising edge.
- `sys_rst`  in  1  reset, asynchronous, active-high.
- `tx_start`  in  1  one-cycle request; sampled only in IDLE.
- `pack_len`  in  8  payload byte count, valid with `tx_start`.
- `tx_data0` … `tx_data10`  in  8 each  payload bytes; `tx_data0` is sent first (function byte).
- `uart_txd`  out  1  serial output, idle high.
- `tx_busy`  out  1  high while a frame is in progress.
- `tx_done`  out  1  one-cycle pulse at end of frame.
- `byte_cnt`  out  4  index of the frame byte currently on the line (0 = header).

## Operation
- Reset values: `uart_txd`=1, `tx_busy`=0, `tx_done`=0, `byte_cnt`=0. All counters and the CRC are 0. State is IDLE.
- Frame byte order: `HEADER`, then `len`, then `tx_data0`..`tx_data[len-1]`, then CRC8 (if enabled). Total `len+2` bytes without CRC, `len+3` with CRC.
- Length rules:
  - `pack_len`=0: the request is ignored. No busy, no done.
  - `pack_len`>11: clamped to 11. The length byte sent is the clamped value.
- All payload inputs and `len` are latched into an internal 11×8 buffer in the accept cycle. Input changes after that have no effect on the frame in progress.
- States:
  - IDLE: on `tx_start` with len≠0, go to START.
  - START: line 0 for `BPS_CNT` cycles, then go to DATA.
  - DATA: 8 bits, LSB first, `BPS_CNT` cycles each, then go to STOP.
  - STOP: line 1 for `BPS_CNT` cycles. Then go to START if bytes remain (`byte_cnt`+1), otherwise go to DONE.
  - DONE: one cycle, then go to IDLE.
- `tx_start` while `tx_busy`=1 is ignored. It is not queued.
- Reset asserted mid-frame: `uart_txd` goes to 1 immediately (asynchronous), the frame is abandoned and state returns to IDLE. No `tx_done` pulse.

## Timing
- `tx_start` high in cycle k: `uart_txd` is 0 and `tx_busy` is 1 from cycle k+1.
- Each bit holds for exactly `BPS_CNT` cycles. There is no idle gap between bytes: the next start bit directly follows the previous stop bit.
- Frame duration is F×10×`BPS_CNT` cycles, where F is the number of frame bytes.
- After the last stop bit, `tx_done`=1 for one cycle, and `tx_busy` falls in that same cycle. The earliest next accept is the following cycle.
- `byte_cnt` increments on the first cycle of each start bit.

## Configuration
- `UART_TX_CRC8_EN` defined:
  - A CRC8 byte is appended to the frame: poly x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
  - The CRC covers the length byte and the payload bytes. The header is excluded.
  - The CRC is computed byte-serially while transmitting, so there is no extra latency.
- Macro undefined: no CRC logic is built, and the frame ends after the last payload byte.

## Test plan
Benches use `CLK_FREQ`=1_000_000 and `UART_BPS`=100_000, giving `BPS_CNT`=10.
- CRC disabled; `pack_len`=1, `tx_data0`=0x01 → bytes 0x5A, 0x01, 0x01; `tx_done` exactly 300 cycles after the first start-bit cycle.
- CRC enabled, same stimulus → bytes 0x5A, 0x01, 0x01, 0x12; 400 cycles.
- `pack_len`=11, payload 0x00..0x0A → 13 bytes (14 with CRC), contiguous with no gaps; every bit period is 10 cycles; `byte_cnt` sequence is 0..12.
- `pack_len`=0 → line stays high, `tx_busy` stays 0, no `tx_done`. `pack_len`=15 → length byte 0x0B and 11 payload bytes.
- Second `tx_start` pulsed mid-frame, with different data → ignored; the first frame completes unchanged, with a single `tx_done`.
- `sys_rst` pulsed during byte 3 → `uart_txd`=1 and `tx_busy`=0 within the reset, no `tx_done`; a new `tx_start` afterwards sends a complete, correct frame.
